// File: rtl/ram_port_arb.sv
// ram_port_arb
//   Arbitrates four single-beat requesters onto the two ports (A and B) of a
//   dual-port RAM with registered read data. Up to two requesters are granted
//   per cycle in rotating priority order, starting at rr_ptr. The first valid
//   requester goes to port A and the second to port B. Read data is returned
//   to the originating requester a fixed number of cycles after acceptance.
//
//   Build option: define RAM_PORT_ARB_FIXED_PRIO_EN to fix priority at
//   0>1>2>3 (rr_ptr held at 0). Round-robin rotation applies when it is
//   undefined.
//
// Ports
//   clk                    clock, rising edge
//   sclr                   synchronous active-high reset
//   req_valid[3:0]         request valid, one bit per requester
//   req_we[3:0]            1 = write, 0 = read
//   req_addr[23:0]         6-bit address per requester, lane i at [6i+5:6i]
//   req_wdata[31:0]        8-bit write data per requester, lane i at [8i+7:8i]
//   req_ready[3:0]         grant; transfer on valid & ready at a rising edge
//   rsp_valid[3:0]         read response valid per requester
//   rsp_rdata[31:0]        read data per requester, zero when not valid
//   ram_addr_a/_b          RAM port address
//   ram_din_a/_b           RAM port write data
//   ram_we_a/_b            RAM write enable, active-low (0 = write)
//   ram_dout_a/_b          RAM registered read data
//   ram_sclr               RAM output clear, active-low
module ram_port_arb #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic                  clk,
  input  logic                  sclr,
  input  logic [3:0]            req_valid,
  input  logic [3:0]            req_we,
  input  logic [4*ADDR_W-1:0]   req_addr,
  input  logic [4*DATA_W-1:0]   req_wdata,
  output logic [3:0]            req_ready,
  output logic [3:0]            rsp_valid,
  output logic [4*DATA_W-1:0]   rsp_rdata,
  output logic [ADDR_W-1:0]     ram_addr_a,
  output logic [ADDR_W-1:0]     ram_addr_b,
  output logic [DATA_W-1:0]     ram_din_a,
  output logic [DATA_W-1:0]     ram_din_b,
  output logic                  ram_we_a,
  output logic                  ram_we_b,
  input  logic [DATA_W-1:0]     ram_dout_a,
  input  logic [DATA_W-1:0]     ram_dout_b,
  output logic                  ram_sclr
);

  function automatic logic [ADDR_W-1:0] addr_lane(input logic [4*ADDR_W-1:0] v,
                                                  input logic [1:0] i);
    return v[int'(i)*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] data_lane(input logic [4*DATA_W-1:0] v,
                                                  input logic [1:0] i);
    return v[int'(i)*DATA_W +: DATA_W];
  endfunction

  logic [1:0]       rr_ptr;
  logic [1:0]       rr_nxt;
  logic [1:0]       scan_idx;
  logic             gnt_a_vld;
  logic [1:0]       gnt_a_idx;
  logic             cand_b_vld;
  logic [1:0]       cand_b_idx;
  logic             hazard;
  logic             gnt_b_vld;
  logic [1:0]       gnt_b_idx;

  // Response tracking, one slot per port: index 0 = port A, index 1 = port B.
  logic [1:0]       vld_p0;
  logic [1:0][1:0]  id_p0;
  logic [1:0]       vld_p1;
  logic [1:0][1:0]  id_p1;
  logic [3:0]            rsp_valid_nxt;
  logic [4*DATA_W-1:0]   rsp_rdata_nxt;

  // Scan requesters in priority order starting at rr_ptr. Nothing is
  // granted while sclr is high.
  always_comb begin
    scan_idx   = rr_ptr;
    gnt_a_vld  = 1'b0;
    gnt_a_idx  = '0;
    cand_b_vld = 1'b0;
    cand_b_idx = '0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = rr_ptr + 2'(k);
      if (req_valid[scan_idx] && !sclr) begin
        if (!gnt_a_vld) begin
          gnt_a_vld = 1'b1;
          gnt_a_idx = scan_idx;
        end else if (!cand_b_vld) begin
          cand_b_vld = 1'b1;
          cand_b_idx = scan_idx;
        end
      end
    end
  end

  // Same-address pair involving a write: the second candidate waits and
  // port B idles rather than being offered to a later requester, so the
  // ordering between the two accesses stays unambiguous.
  assign hazard    = gnt_a_vld && cand_b_vld &&
                     (addr_lane(req_addr, gnt_a_idx) == addr_lane(req_addr, cand_b_idx)) &&
                     (req_we[gnt_a_idx] || req_we[cand_b_idx]);
  assign gnt_b_vld = cand_b_vld && !hazard;
  assign gnt_b_idx = cand_b_idx;

  // Grants come only from req_valid and the grant scan, never from req_ready.
  always_comb begin
    req_ready = '0;
    if (gnt_a_vld) req_ready[gnt_a_idx] = 1'b1;
    if (gnt_b_vld) req_ready[gnt_b_idx] = 1'b1;
  end

`ifdef RAM_PORT_ARB_FIXED_PRIO_EN
  // Pointer parked at 0 so the scan always starts at requester 0.
  assign rr_nxt = 2'd0;
`else
  always_comb begin
    rr_nxt = rr_ptr;
    if (gnt_b_vld)      rr_nxt = gnt_b_idx + 2'd1;
    else if (gnt_a_vld) rr_nxt = gnt_a_idx + 2'd1;
  end
`endif

  // Build next-cycle responses from the tracking slot whose RAM read
  // completed on the previous edge; unused lanes stay zero.
  always_comb begin
    rsp_valid_nxt = '0;
    rsp_rdata_nxt = '0;
    if (vld_p1[0]) begin
      rsp_valid_nxt[id_p1[0]] = 1'b1;
      rsp_rdata_nxt[int'(id_p1[0])*DATA_W +: DATA_W] = ram_dout_a;
    end
    if (vld_p1[1]) begin
      rsp_valid_nxt[id_p1[1]] = 1'b1;
      rsp_rdata_nxt[int'(id_p1[1])*DATA_W +: DATA_W] = ram_dout_b;
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      rr_ptr     <= '0;
      vld_p0     <= '0;
      vld_p1     <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      ram_we_a   <= 1'b1;
      ram_addr_a <= '0;
      ram_din_a  <= '0;
      ram_we_b   <= 1'b1;
      ram_addr_b <= '0;
      ram_din_b  <= '0;
    end else begin
      rr_ptr <= rr_nxt;

      // ---- p0: accepted request driven onto its RAM port for one cycle ----
      if (gnt_a_vld) begin
        ram_we_a   <= ~req_we[gnt_a_idx];
        ram_addr_a <= addr_lane(req_addr, gnt_a_idx);
        ram_din_a  <= data_lane(req_wdata, gnt_a_idx);
      end else begin
        ram_we_a   <= 1'b1;
        ram_addr_a <= '0;
        ram_din_a  <= '0;
      end
      if (gnt_b_vld) begin
        ram_we_b   <= ~req_we[gnt_b_idx];
        ram_addr_b <= addr_lane(req_addr, gnt_b_idx);
        ram_din_b  <= data_lane(req_wdata, gnt_b_idx);
      end else begin
        ram_we_b   <= 1'b1;
        ram_addr_b <= '0;
        ram_din_b  <= '0;
      end
      vld_p0 <= {gnt_b_vld & ~req_we[gnt_b_idx], gnt_a_vld & ~req_we[gnt_a_idx]};

      // ---- p1: RAM samples the port; its dout is valid after this edge ----
      vld_p1 <= vld_p0;

      // ---- response: dout captured into the requester's lane ----
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
    end
  end

  // Requester ids follow their valid bits; a cleared valid makes them inert.
  always_ff @(posedge clk) begin
    id_p0[0] <= gnt_a_idx;
    id_p0[1] <= gnt_b_idx;
    id_p1    <= id_p0;
  end

  always_ff @(posedge clk) begin
    ram_sclr <= ~sclr;
  end

endmodule

// File: tb/tb_ram_port_arb.sv
module tb_ram_port_arb;

  logic        clk = 1'b0;
  logic        sclr;
  logic [3:0]  req_valid, req_we, req_ready, rsp_valid;
  logic [23:0] req_addr;
  logic [31:0] req_wdata, rsp_rdata;
  logic [5:0]  ram_addr_a, ram_addr_b;
  logic [7:0]  ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;
  logic        ram_we_a, ram_we_b, ram_sclr;

  always #5 clk = ~clk;

  ram_port_arb dut (
    .clk        (clk),
    .sclr       (sclr),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .ram_addr_a (ram_addr_a),
    .ram_addr_b (ram_addr_b),
    .ram_din_a  (ram_din_a),
    .ram_din_b  (ram_din_b),
    .ram_we_a   (ram_we_a),
    .ram_we_b   (ram_we_b),
    .ram_dout_a (ram_dout_a),
    .ram_dout_b (ram_dout_b),
    .ram_sclr   (ram_sclr)
  );

  // Dual-port RAM model: registered read, active-low write, active-low clear.
  logic [7:0] ram_mem [64];
  bit         ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 64; i++) ram_mem[i] = 8'(i * 7 + 3);
      ram_init = 1'b1;
    end
    if (ram_sclr === 1'b0) begin
      ram_dout_a <= 8'h00;
      ram_dout_b <= 8'h00;
    end else begin
      ram_dout_a <= ram_mem[ram_addr_a];
      ram_dout_b <= ram_mem[ram_addr_b];
    end
    if (ram_we_a === 1'b0) ram_mem[ram_addr_a] = ram_din_a;
    if (ram_we_b === 1'b0) ram_mem[ram_addr_b] = ram_din_b;
  end

  typedef struct {
    int         due;
    int         req;
    logic [7:0] data;
  } rsp_t;

  rsp_t       sbq[$];
  logic [7:0] exp_mem [64];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  bit         mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ports(input string tag,
                           input logic we_a, input logic [5:0] a_a, input logic [7:0] d_a,
                           input logic we_b, input logic [5:0] a_b, input logic [7:0] d_b);
    chk({tag, " portA"}, 32'({ram_we_a, ram_addr_a, ram_din_a}), 32'({we_a, a_a, d_a}));
    chk({tag, " portB"}, 32'({ram_we_b, ram_addr_b, ram_din_b}), 32'({we_b, a_b, d_b}));
  endtask

  // Pop every response due this cycle and compare the full output vectors.
  task automatic check_rsp();
    logic [3:0]  ev;
    logic [31:0] ed;
    rsp_t        e;
    ev = '0;
    ed = '0;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      if (e.due == cyc) begin
        ev[e.req]          = 1'b1;
        ed[e.req*8 +: 8]   = e.data;
      end
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    chk("rsp_rdata", rsp_rdata, ed);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mon_en) check_rsp();
  endtask

  // Drive one cycle of requests, check the grant, record expectations.
  task automatic step(input logic [3:0] v, input logic [3:0] we,
                      input logic [23:0] addr, input logic [31:0] wd,
                      input logic [3:0] exp_ready, input string tag);
    rsp_t e;
    req_valid = v;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    #1;
    chk({tag, " ready"}, 32'(req_ready), 32'(exp_ready));
    for (int i = 0; i < 4; i++) begin
      if (exp_ready[i] && v[i]) begin
        if (!we[i]) begin
          e.due  = cyc + 3;
          e.req  = i;
          e.data = exp_mem[addr[i*6 +: 6]];
          sbq.push_back(e);
        end else begin
          exp_mem[addr[i*6 +: 6]] = wd[i*8 +: 8];
        end
      end
    end
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 4'b0000, 24'd0, 32'd0, 4'b0000, "idle");
  endtask

  initial begin
    logic [3:0] exp_pair;
    for (int i = 0; i < 64; i++) exp_mem[i] = 8'(i * 7 + 3);

    // Reset: no grants while sclr is high, all outputs at reset values.
    sclr      = 1'b1;
    req_valid = 4'hF;
    req_we    = 4'h0;
    req_addr  = 24'd0;
    req_wdata = 32'd0;
    tick();
    chk("rst ready", 32'(req_ready), 32'd0);
    chk_ports("rst", 1'b1, 6'd0, 8'h00, 1'b1, 6'd0, 8'h00);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'd0);
    chk("rst ram_sclr", 32'(ram_sclr), 32'd0);
    chk("rst rr_ptr", 32'(dut.rr_ptr), 32'd0);
    sclr      = 1'b0;
    req_valid = 4'h0;
    tick();
    chk("ram_sclr release", 32'(ram_sclr), 32'd1);
    mon_en = 1'b1;

    // Write then read back the same address through port A.
    step(4'b0001, 4'b0001, {18'd0, 6'd5}, {24'd0, 8'hA5}, 4'b0001, "wr5");
    chk_ports("wr5", 1'b0, 6'd5, 8'hA5, 1'b1, 6'd0, 8'h00);
    step(4'b0001, 4'b0000, {18'd0, 6'd5}, 32'd0, 4'b0001, "rd5");
    chk_ports("rd5", 1'b1, 6'd5, 8'h00, 1'b1, 6'd0, 8'h00);
    idle(1);
    chk_ports("idle", 1'b1, 6'd0, 8'h00, 1'b1, 6'd0, 8'h00);
    idle(2);

    // Only requester 3 reading: port A every cycle, pointer wraps to 0.
    for (int k = 0; k < 4; k++) begin
      step(4'b1000, 4'b0000, {6'(30 + k), 18'd0}, 32'd0, 4'b1000, "r3");
      chk_ports("r3", 1'b1, 6'(30 + k), 8'h00, 1'b1, 6'd0, 8'h00);
      chk("r3 rr_ptr", 32'(dut.rr_ptr), 32'd0);
    end
    idle(3);

`ifndef RAM_PORT_ARB_FIXED_PRIO_EN
    // All four reading continuously: pairs {0,1},{2,3} alternate.
    for (int k = 0; k < 4; k++) begin
      exp_pair = (k % 2 == 0) ? 4'b0011 : 4'b1100;
      step(4'b1111, 4'b0000, {6'd13, 6'd12, 6'd11, 6'd10}, 32'd0, exp_pair, "rr4");
      if (k % 2 == 0) chk_ports("rr4", 1'b1, 6'd10, 8'h00, 1'b1, 6'd11, 8'h00);
      else            chk_ports("rr4", 1'b1, 6'd12, 8'h00, 1'b1, 6'd13, 8'h00);
    end
`else
    // Fixed priority with 0,1,3 valid: requester 3 starves, pointer stays 0.
    for (int k = 0; k < 4; k++) begin
      exp_pair = 4'b0011;
      step(4'b1011, 4'b0000, {6'd13, 6'd12, 6'd11, 6'd10}, 32'd0, exp_pair, "fix");
      chk_ports("fix", 1'b1, 6'd10, 8'h00, 1'b1, 6'd11, 8'h00);
      chk("fix rr_ptr", 32'(dut.rr_ptr), 32'd0);
    end
`endif
    idle(3);

    // Same-address write/read: second grant withheld, port B idle.
    step(4'b0110, 4'b0010, {6'd0, 6'd9, 6'd9, 6'd0}, {8'h00, 8'h00, 8'h5A, 8'h00}, 4'b0010, "wr9");
    chk_ports("wr9", 1'b0, 6'd9, 8'h5A, 1'b1, 6'd0, 8'h00);
    step(4'b0100, 4'b0000, {6'd0, 6'd9, 6'd0, 6'd0}, 32'd0, 4'b0100, "rd9");
    chk_ports("rd9", 1'b1, 6'd9, 8'h00, 1'b1, 6'd0, 8'h00);

    // Distinct addresses: read on port A alongside a write on port B.
    step(4'b0011, 4'b0010, {6'd0, 6'd0, 6'd7, 6'd8}, {8'h00, 8'h00, 8'h77, 8'h00}, 4'b0011, "rd8wr7");
    chk_ports("rd8wr7", 1'b1, 6'd8, 8'h00, 1'b0, 6'd7, 8'h77);
    step(4'b0100, 4'b0000, {6'd0, 6'd7, 6'd0, 6'd0}, 32'd0, 4'b0100, "rd7");
    idle(3);

    // Reset one edge after reads are accepted: those reads never respond.
    step(4'b0011, 4'b0000, {6'd0, 6'd0, 6'd21, 6'd20}, 32'd0, 4'b0011, "pre");
    sbq.delete();
    sclr      = 1'b1;
    req_valid = 4'hF;
    #1;
    chk("sclr ready", 32'(req_ready), 32'd0);
    tick();
    chk_ports("sclr", 1'b1, 6'd0, 8'h00, 1'b1, 6'd0, 8'h00);
    chk("sclr ram_sclr", 32'(ram_sclr), 32'd0);
    chk("sclr rr_ptr", 32'(dut.rr_ptr), 32'd0);
    sclr      = 1'b0;
    req_valid = 4'h0;
    tick();
    chk("sclr ram_sclr rel", 32'(ram_sclr), 32'd1);
    idle(3);

    // Normal operation resumes after the reset.
    step(4'b0010, 4'b0000, {6'd0, 6'd0, 6'd40, 6'd0}, 32'd0, 4'b0010, "post");
    idle(3);
    chk("sb empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arb.md
RAM_PORT_ARB -- requirements
Module: ram_port_arb

Interface
REQ-001 The block SHALL use one clock, clk; the reset is sclr, synchronous and active-high.
REQ-002 The block SHALL have the following ports:
- clk  in  1  clock; all state updates on the rising edge
- sclr  in  1  synchronous active-high reset
- req_valid  in  4  request valid, one bit per requester i=0..3
- req_we  in  4  1=write, 0=read, per requester
- req_addr  in  24  6-bit address per requester, requester i at bits [6i+5:6i]
- req_wdata  in  32  8-bit write data per requester, requester i at bits [8i+7:8i]
- req_ready  out  4  grant; a request transfers when valid&ready are high at a rising edge
- rsp_valid  out  4  read-data valid per requester
- rsp_rdata  out  32  8-bit read data per requester, same packing as req_wdata
- ram_addr_a, ram_addr_b  out  6  RAM port addresses
- ram_din_a, ram_din_b  out  8  RAM write data
- ram_we_a, ram_we_b  out  1  RAM write enable, active-low (0=write, 1=read)
- ram_dout_a, ram_dout_b  in  8  RAM registered read data
- ram_sclr  out  1  RAM output clear, active-low

Function
REQ-003 The block SHALL combinationally grant at most two requesters per cycle: the first valid requester in priority order gets port A and the second gets port B.
REQ-004 Priority order SHALL start at rr_ptr (2 bits) and wrap 3->0.
REQ-005 req_ready[i] SHALL be high only for granted requesters and SHALL NOT depend on req_ready itself (no combinational loop).
REQ-006 A second grant SHALL be withheld when its address equals the first grant's address and either request is a write; the withheld requester waits, and port B idles that cycle.
REQ-007 On each accepted request, the block SHALL register addr, wdata and we (inverted to active-low) onto the assigned port for exactly one cycle.
REQ-008 An idle port SHALL drive we=1, addr=0 and din=0.
REQ-009 Read latency SHALL be fixed: for a read accepted at edge N, the RAM samples at edge N+1 and rsp_valid[i] is high for exactly the one cycle after edge N+2.
REQ-010 During that response cycle, rsp_rdata[i] SHALL hold the dout of the port that served the request; rsp_rdata lanes SHALL be 0 when not valid.
REQ-011 Writes SHALL produce no response.
REQ-012 Response tracking SHALL be a 2-stage pipeline per port (valid, requester id, port); back-to-back reads at one per port per cycle SHALL be supported with no bubbles.
REQ-013 After any cycle with at least one grant, rr_ptr SHALL become (last granted index + 1) mod 4; with no grant, rr_ptr SHALL be unchanged.
REQ-014 A single requester SHALL never be granted both ports in one cycle.
REQ-015 ram_sclr SHALL equal ~sclr registered (low for the cycle after each reset edge).

Reset
REQ-016 When sclr is high at a rising edge, the block SHALL set rr_ptr=0, clear response pipelines, and drive ram_we_a/b=1, ram_addr_*=0, ram_din_*=0, rsp_valid=0, rsp_rdata=0.
REQ-017 While sclr is high, req_ready SHALL be 0.
REQ-018 Reads in flight when reset asserts SHALL be discarded; no rsp_valid is emitted for them.

Configuration
REQ-019 With RAM_PORT_ARB_FIXED_PRIO_EN defined, priority SHALL be fixed at 0>1>2>3, and rr_ptr SHALL be held at 0.
REQ-020 Without RAM_PORT_ARB_FIXED_PRIO_EN, the round-robin behaviour of REQ-004 and REQ-013 SHALL apply.

Verification
REQ-021 The bench SHALL cover: reset, then req 0 writes addr 5 data 0xA5; next cycle req 0 reads addr 5 -> port A carries we=0/addr 5 one cycle after the write accept, and rsp_valid[0]=1 with rsp_rdata[0]=0xA5 in the cycle after edge N+2 of the read.
REQ-022 The bench SHALL cover: all four requesters continuously valid reading distinct addresses -> grants {0,1},{2,3},{0,1} on successive cycles, each requester responding every other cycle.
REQ-023 The bench SHALL cover: req 1 writes addr 9 and req 2 reads addr 9 in the same cycle -> only req 1 granted, port B idle (we=1), req 2 granted next cycle and reading the new data.
REQ-024 The bench SHALL cover: reads issued, then sclr pulsed high at edge N+1 -> no rsp_valid for those reads, all outputs at reset values, and ram_sclr low for one cycle.
REQ-025 The bench SHALL cover: with RAM_PORT_ARB_FIXED_PRIO_EN defined and reqs 0,1,3 continuously valid -> req 3 never granted, rr_ptr stays 0.
REQ-026 The bench SHALL cover: only req 3 valid, reading -> granted port A every cycle, one response per cycle, and rr_ptr wraps to 0.
